// File: rtl/mac_io_pkg.sv
// Shared types and sizing helpers for the MAC result unloader and its FIFO.
package mac_io_pkg;

    localparam int ACC_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 4;

    // Byte-streaming FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Number of bytes in one accumulator word
    function automatic int nbytes(input int acc_w);
        return acc_w / 8;
    endfunction

    // Width of the byte index counter (at least one bit)
    function automatic int byte_idx_w(input int acc_w);
        return (acc_w / 8 > 1) ? $clog2(acc_w / 8) : 1;
    endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Small circular FIFO holding accumulator results until they are streamed out.
// Exposes both the head entry and the entry behind it so the reader FSM can
// move straight on to the next result in the cycle it retires the head.
module mac_result_fifo #(
    parameter int ACC_W = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ACC_W-1:0] push_data,
    input  logic             pop,
    output logic [ACC_W-1:0] head_data,
    output logic [ACC_W-1:0] next_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [ACC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered count, so a push while full is refused
    // even if the head is retired in the same cycle.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PTR_W'(1)];

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_unloader.sv
// Reader side of the MAC test datapath: buffers accumulator results and
// streams each one LS byte first over a 4-phase strobe/ack pin handshake.
//
// Handshake: the unit raises out_strobe with out_byte (and out_last) stable;
// the reader raises out_ack once it has taken the byte; the unit then drops
// out_strobe; the reader drops out_ack; only after the synchronised ack is
// seen low does the unit present the next byte. out_ack is asynchronous and
// is only used after a two-flop synchronizer.
module mac_result_unloader
    import mac_io_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   acc_valid,
    input  logic [ACC_W-1:0]       acc_data,
    output logic                   acc_ready,
    output logic [7:0]             out_byte,
    output logic                   out_strobe,
    output logic                   out_last,
    input  logic                   out_ack,
    input  logic                   clear_ovf,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count,
    output state_e                 state
);

    localparam int NBYTES = nbytes(ACC_W);
    localparam int IDX_W  = byte_idx_w(ACC_W);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [ACC_W-1:0] head_data;
    logic [ACC_W-1:0] next_data;
    logic             full;
    logic             empty;
    logic             pop;
    logic             ack_meta;
    logic             ack_s;
    logic [IDX_W-1:0] byte_idx;

    // Byte lane of a word, lane 0 being the least significant
    function automatic logic [7:0] byte_of(input logic [ACC_W-1:0] w,
                                           input logic [IDX_W-1:0] i);
        return w[8*int'(i) +: 8];
    endfunction

    assign acc_ready = !full;

    // The head stays counted until its final ack has fallen
    assign pop = (state == RELEASE) && !ack_s && (byte_idx == LAST_IDX);

    mac_result_fifo #(
        .ACC_W (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (acc_valid),
        .push_data (acc_data),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    // Two-flop synchronizer for the asynchronous reader acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= out_ack;
            ack_s    <= ack_meta;
        end
    end

    // Sticky overflow: a refused push sets it, and wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (acc_valid && !acc_ready) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Byte-streaming FSM with registered strobe/byte/last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_idx   <= '0;
            out_byte   <= 8'h00;
            out_strobe <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        byte_idx   <= '0;
                        out_byte   <= byte_of(head_data, '0);
                        out_strobe <= 1'b1;
                        out_last   <= (LAST_IDX == '0);
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_s) begin
                        out_strobe <= 1'b0;
                        out_last   <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        if (byte_idx != LAST_IDX) begin
                            byte_idx   <= byte_idx + IDX_W'(1);
                            out_byte   <= byte_of(head_data, byte_idx + IDX_W'(1));
                            out_strobe <= 1'b1;
                            out_last   <= ((byte_idx + IDX_W'(1)) == LAST_IDX);
                            state      <= PRESENT;
                        end else begin
                            // Head retires this cycle; a push landing now is not
                            // yet in the count, so it is picked up from IDLE.
                            byte_idx <= '0;
                            if (fifo_count > CNT_W'(1)) begin
                                out_byte   <= byte_of(next_data, '0);
                                out_strobe <= 1'b1;
                                out_last   <= (LAST_IDX == '0);
                                state      <= PRESENT;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_result_unloader.sv
// Directed and randomised bench for mac_result_unloader.
module tb_mac_result_unloader;
    import mac_io_pkg::*;

    localparam int ACC_W = 16;
    localparam int DEPTH = 4;
    localparam int NB    = ACC_W / 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         acc_valid;
    logic [15:0]  acc_data;
    logic         acc_ready;
    logic [7:0]   out_byte;
    logic         out_strobe;
    logic         out_last;
    logic         out_ack;
    logic         clear_ovf;
    logic         overflow;
    logic [2:0]   fifo_count;
    state_e       dbg_state;

    logic         man_ack = 1'b0;
    logic         rd_ack  = 1'b0;
    assign out_ack = man_ack | rd_ack;

    always #5 clk = ~clk;

    mac_result_unloader #(.ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .acc_ready  (acc_ready),
        .out_byte   (out_byte),
        .out_strobe (out_strobe),
        .out_last   (out_last),
        .out_ack    (out_ack),
        .clear_ovf  (clear_ovf),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    bit          reader_en = 1'b0;
    bit          rand_dly  = 1'b0;
    int          ack_dly   = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input logic lvl, input string tag);
        int n = 0;
        while (out_strobe !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(out_strobe), 32'(lvl));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_count != 3'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_count_zero"}, 32'(fifo_count), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; holds acc_valid across exactly one rising edge.
    task automatic push(input logic [15:0] d, input bit track, output bit accepted);
        acc_valid = 1'b1;
        acc_data  = d;
        accepted  = acc_ready;
        if (track && accepted) exp_q.push_back(d);
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    // Reader model: takes each byte, acks after a delay, reassembles results
    initial begin
        int          bidx = 0;
        logic [15:0] asm_w = '0;
        logic [7:0]  b;
        logic        l;
        int          d;
        forever begin
            @(negedge clk);
            if (reader_en && out_strobe === 1'b1) begin
                b = out_byte;
                l = out_last;
                chk("rd_last_flag", 32'(l), 32'(bidx == NB - 1));
                asm_w[bidx*8 +: 8] = b;
                d = rand_dly ? int'($urandom_range(0, 10)) : ack_dly;
                repeat (d) @(negedge clk);
                chk("rd_byte_stable", 32'(out_byte), 32'(b));
                rd_ack = 1'b1;
                wait_strobe(1'b0, "rd_strobe_fall");
                rd_ack = 1'b0;
                if (l) begin
                    if (exp_q.size() == 0)
                        chk("rd_unexpected_result", 32'(asm_w), 32'h10000);
                    else
                        chk("rd_result", 32'(asm_w), 32'(exp_q.pop_front()));
                    bidx = 0;
                end else begin
                    bidx = (bidx + 1) % NB;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit a;
        int refused;
        logic [15:0] d;

        // Reset state
        rst = 1'b1; acc_valid = 1'b0; acc_data = '0; clear_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_strobe", 32'(out_strobe), 32'd0);
        chk("rst_byte", 32'(out_byte), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(acc_ready), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Single result 0xBEEF, manual ack after 3 cycles
        push(16'hBEEF, 1'b0, a);
        chk("t2_accepted", 32'(a), 32'd1);
        chk("t2_count_after_push", 32'(fifo_count), 32'd1);
        chk("t2_strobe_not_yet", 32'(out_strobe), 32'd0);
        @(negedge clk);
        chk("t2_strobe_rise", 32'(out_strobe), 32'd1);
        chk("t2_byte0", 32'(out_byte), 32'hEF);
        chk("t2_last0", 32'(out_last), 32'd0);
        repeat (3) @(negedge clk);
        man_ack = 1'b1;
        wait_strobe(1'b0, "t2_fall0");
        man_ack = 1'b0;
        wait_strobe(1'b1, "t2_rise1");
        chk("t2_byte1", 32'(out_byte), 32'hBE);
        chk("t2_last1", 32'(out_last), 32'd1);
        repeat (3) @(negedge clk);
        man_ack = 1'b1;
        wait_strobe(1'b0, "t2_fall1");
        chk("t2_count_held", 32'(fifo_count), 32'd1);
        man_ack = 1'b0;
        begin
            int n = 0;
            while (fifo_count != 3'd0 && n < 20) begin @(negedge clk); n++; end
        end
        chk("t2_count_final", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_idle", 32'(dbg_state), 32'(IDLE));
        chk("t2_no_strobe", 32'(out_strobe), 32'd0);

        // Fill with ack held low, then drop one
        for (int i = 1; i <= 4; i++) begin
            push(16'(i), 1'b1, a);
            chk("t3_accepted", 32'(a), 32'd1);
        end
        chk("t3_ready_full", 32'(acc_ready), 32'd0);
        chk("t3_count_full", 32'(fifo_count), 32'd4);
        chk("t3_ovf_clear", 32'(overflow), 32'd0);
        push(16'h1234, 1'b1, a);
        chk("t3_refused", 32'(a), 32'd0);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        chk("t3_count_still", 32'(fifo_count), 32'd4);
        ack_dly = 1; rand_dly = 1'b0; reader_en = 1'b1;
        wait_drain("t3_drain");
        reader_en = 1'b0;
        repeat (4) @(negedge clk);

        // Overflow clear, and set-wins against a same-cycle clear
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i), 1'b1, a);
        acc_valid = 1'b1; acc_data = 16'hDEAD; clear_ovf = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0; clear_ovf = 1'b0;
        chk("t4_set_wins", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("t4_ovf_cleared2", 32'(overflow), 32'd0);
        reader_en = 1'b1;
        wait_drain("t4_drain");
        reader_en = 1'b0;
        repeat (4) @(negedge clk);

        // Reset while presenting with three results held
        for (int i = 0; i < 3; i++) push(16'hB001 + 16'(i), 1'b0, a);
        chk("t5_strobe_high", 32'(out_strobe), 32'd1);
        chk("t5_count3", 32'(fifo_count), 32'd3);
        chk("t5_present", 32'(dbg_state), 32'(PRESENT));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_strobe", 32'(out_strobe), 32'd0);
        chk("t5_rst_byte", 32'(out_byte), 32'd0);
        chk("t5_rst_last", 32'(out_last), 32'd0);
        chk("t5_rst_count", 32'(fifo_count), 32'd0);
        chk("t5_rst_ready", 32'(acc_ready), 32'd1);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_quiet_strobe", 32'(out_strobe), 32'd0);
        end
        reader_en = 1'b1;
        push(16'hA5C3, 1'b1, a);
        wait_drain("t5_drain");

        // Random back-to-back pushes while draining
        rand_dly = 1'b1;
        refused  = 0;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            chk("t6_ovf_iff_refused", 32'(overflow), 32'(refused > 0));
            chk("t6_ready_vs_count", 32'(acc_ready), 32'(fifo_count != 3'(DEPTH)));
            d = 16'($urandom);
            push(d, 1'b1, a);
            if (!a) begin
                refused++;
                chk("t6_ovf_after_drop", 32'(overflow), 32'd1);
            end
        end
        wait_drain("t6_drain");
        chk("t6_ovf_final", 32'(overflow), 32'(refused > 0));
        reader_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
